// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared types and constants for the register writeback block.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int XLEN       = 64;
  localparam int NUM_REGS   = 32;
  localparam int FIFO_DEPTH = 2;

  // One queued result: destination register and the value to write.
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } wb_entry_t;

  // Result source; also the encoding of the round-robin pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_t;

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Brief    : Small circular FIFO of writeback entries; push and pop in the
//            same cycle are both honoured, including when full.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // allowed when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Register update; storage contents need no reset since occupancy gates them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : wb_fifo

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
// Module   : reg_writeback
// Brief    : Merges ALU and load results into one register-file write port
//            with round-robin arbitration and a busy-bit scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_writeback #(
  parameter int XLEN       = wb_pkg::XLEN,       // must match the package width
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_val,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_val,
  output logic            write_sig,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_val,
  output logic [31:0]     commit_count
);

  import wb_pkg::*;

  wb_entry_t alu_in, ld_in, alu_head, ld_head, grant_entry;
  logic      alu_full, alu_empty, ld_full, ld_empty;
  logic      alu_pop, ld_pop;

  src_t                rr_ptr_q, rr_ptr_d;
  logic                write_sig_q, write_sig_d;
  logic [4:0]          write_reg_q, write_reg_d;
  logic [XLEN-1:0]     write_val_q, write_val_d;
  logic [31:0]         commit_count_q, commit_count_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Ready depends only on occupancy, never on the valid inputs.
  assign alu_ready = !alu_full;
  assign ld_ready  = !ld_full;

  assign alu_in = '{rd: alu_rd, val: alu_val};
  assign ld_in  = '{rd: ld_rd,  val: ld_val};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (alu_valid && alu_ready),
    .push_data (alu_in),
    .pop       (alu_pop),
    .head      (alu_head),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_ld_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ld_valid && ld_ready),
    .push_data (ld_in),
    .pop       (ld_pop),
    .head      (ld_head),
    .full      (ld_full),
    .empty     (ld_empty)
  );

  // Arbitration: a lone source always wins; under contention rr_ptr picks and
  // then flips so the other source goes first next time.
  always_comb begin
    alu_pop  = 1'b0;
    ld_pop   = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (!alu_empty && !ld_empty) begin
      if (rr_ptr_q == SRC_ALU) begin
        alu_pop = 1'b1;
      end else begin
        ld_pop  = 1'b1;
      end
      rr_ptr_d = (rr_ptr_q == SRC_ALU) ? SRC_LD : SRC_ALU;
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!ld_empty) begin
      ld_pop  = 1'b1;
    end
    grant_entry = alu_pop ? alu_head : ld_head;
  end

  // Write port: x0 results are consumed silently; address/data hold when idle.
  always_comb begin
    write_sig_d    = (alu_pop || ld_pop) && (grant_entry.rd != 5'd0);
    write_reg_d    = write_sig_d ? grant_entry.rd  : write_reg_q;
    write_val_d    = write_sig_d ? grant_entry.val : write_val_q;
    commit_count_d = commit_count_q + {31'd0, write_sig_q};
  end

  // Scoreboard: clear on retirement, then apply the new reservation so a
  // same-index set overrides the clear; x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (write_sig_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= SRC_ALU;
      write_sig_q    <= 1'b0;
      write_reg_q    <= '0;
      write_val_q    <= '0;
      commit_count_q <= '0;
      busy_q         <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      write_sig_q    <= write_sig_d;
      write_reg_q    <= write_reg_d;
      write_val_q    <= write_val_d;
      commit_count_q <= commit_count_d;
      busy_q         <= busy_d;
    end
  end

  assign write_sig    = write_sig_q;
  assign write_reg    = write_reg_q;
  assign write_val    = write_val_q;
  assign commit_count = commit_count_q;
  assign rs1_busy     = busy_q[q_rs1];
  assign rs2_busy     = busy_q[q_rs2];

endmodule : reg_writeback

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
// Module   : tb_reg_writeback
// Brief    : Directed self-checking bench for reg_writeback.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_writeback;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      q_rs1, q_rs2;
  logic            rs1_busy, rs2_busy;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_val;
  logic            ld_valid, ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_val;
  logic            write_sig;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_val;
  logic [31:0]     commit_count;

  int n_vec  = 0;
  int n_miss = 0;

  reg_writeback #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .q_rs1        (q_rs1),
    .q_rs2        (q_rs2),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_val      (alu_val),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_val       (ld_val),
    .write_sig    (write_sig),
    .write_reg    (write_reg),
    .write_val    (write_val),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and checks both happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu_push(input logic [4:0] rd, input logic [63:0] val);
    alu_valid = 1'b1; alu_rd = rd; alu_val = val;
  endtask

  task automatic ld_push(input logic [4:0] rd, input logic [63:0] val);
    ld_valid = 1'b1; ld_rd = rd; ld_val = val;
  endtask

  task automatic busy_vector(output logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      q_rs1 = 5'(i);
      #1;
      v[i] = rs1_busy;
    end
  endtask

  logic [31:0] bv;

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_rd = '0;
    q_rs1 = '0; q_rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_val = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_val  = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    q_rs1 = 5'd5; #1;
    chk("rst_write_sig", write_sig, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_val", write_val, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_commit", commit_count, 0);
    chk("rst_busy5", rs1_busy, 0);

    // Single ALU result x5=0x1234 with 2-cycle latency
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    chk("x5_busy_set", rs1_busy, 1);
    alu_push(5'd5, 64'h1234);
    tick();                               // accept edge t
    alu_valid = 1'b0;
    chk("x5_lat_t", write_sig, 0);
    tick();                               // t+1
    chk("x5_sig", write_sig, 1);
    chk("x5_reg", write_reg, 5);
    chk("x5_val", write_val, 64'h1234);
    chk("x5_busy_held", rs1_busy, 1);
    tick();                               // t+2
    chk("x5_busy_clr", rs1_busy, 0);
    chk("x5_sig_off", write_sig, 0);
    chk("x5_reg_hold", write_reg, 5);
    chk("x5_commit", commit_count, 1);

    // Simultaneous pair: ALU first, then repeat written load-first
    alu_push(5'd1, 64'hA); ld_push(5'd2, 64'hB);
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    tick();
    chk("pair1_a_reg", write_reg, 1);
    chk("pair1_a_val", write_val, 64'hA);
    tick();
    chk("pair1_b_sig", write_sig, 1);
    chk("pair1_b_reg", write_reg, 2);
    chk("pair1_b_val", write_val, 64'hB);
    tick();
    chk("pair1_idle", write_sig, 0);
    alu_push(5'd1, 64'hC); ld_push(5'd2, 64'hD);
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    tick();
    chk("pair2_first_reg", write_reg, 2);
    chk("pair2_first_val", write_val, 64'hD);
    tick();
    chk("pair2_second_reg", write_reg, 1);
    chk("pair2_second_val", write_val, 64'hC);
    tick();
    chk("pair2_idle", write_sig, 0);
    chk("pair2_commit", commit_count, 5);

    // Back-pressure: 3 ALU results in 3 cycles alongside 2 loads
    alu_push(5'd10, 64'h100); ld_push(5'd20, 64'h200);
    tick();                               // E1
    alu_push(5'd11, 64'h101); ld_push(5'd21, 64'h201);
    tick();                               // E2
    chk("bp_w1_reg", write_reg, 10);
    chk("bp_w1_val", write_val, 64'h100);
    chk("bp_alu_ready_1", alu_ready, 1);
    chk("bp_ld_ready_full", ld_ready, 0);
    alu_push(5'd12, 64'h102); ld_valid = 1'b0;
    tick();                               // E3
    alu_valid = 1'b0;
    chk("bp_w2_reg", write_reg, 20);
    chk("bp_alu_ready_full", alu_ready, 0);
    tick();                               // E4
    chk("bp_w3_reg", write_reg, 11);
    chk("bp_w3_val", write_val, 64'h101);
    chk("bp_alu_ready_back", alu_ready, 1);
    tick();                               // E5
    chk("bp_w4_reg", write_reg, 21);
    tick();                               // E6
    chk("bp_w5_sig", write_sig, 1);
    chk("bp_w5_reg", write_reg, 12);
    chk("bp_w5_val", write_val, 64'h102);
    tick();                               // E7
    chk("bp_drained", write_sig, 0);
    chk("bp_commit", commit_count, 10);

    // Load to x0: consumed, never written
    ld_push(5'd0, 64'hFFFF);
    tick();
    ld_valid = 1'b0;
    chk("x0_ld_ready", ld_ready, 1);
    tick();
    chk("x0_no_sig", write_sig, 0);
    chk("x0_reg_hold", write_reg, 12);
    chk("x0_val_hold", write_val, 64'h102);
    tick();
    chk("x0_commit", commit_count, 10);

    // Re-reservation of x7 coinciding with its own retirement: set wins
    q_rs1 = 5'd7; q_rs2 = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    alu_push(5'd7, 64'h77);
    tick();
    alu_valid = 1'b0;
    chk("x7_busy_pre", rs1_busy, 1);
    tick();
    chk("x7_sig", write_sig, 1);
    chk("x7_reg", write_reg, 7);
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("x7_busy_rs1", rs1_busy, 1);
    chk("x7_busy_rs2", rs2_busy, 1);
    chk("x7_commit", commit_count, 11);

    // Reset with queued results and busy bits pending
    alu_push(5'd13, 64'h13); ld_push(5'd14, 64'h14);
    tick();
    alu_push(5'd15, 64'h15); ld_push(5'd16, 64'h16);
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("prerst_ld_full", ld_ready, 0);
    chk("prerst_sig", write_sig, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_sig", write_sig, 0);
    chk("mrst_alu_ready", alu_ready, 1);
    chk("mrst_ld_ready", ld_ready, 1);
    chk("mrst_commit", commit_count, 0);
    chk("mrst_reg", write_reg, 0);
    tick();
    chk("mrst_sig_1", write_sig, 0);
    tick();
    chk("mrst_sig_2", write_sig, 0);
    chk("mrst_commit_2", commit_count, 0);
    busy_vector(bv);
    chk("mrst_busy_all", bv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_reg_writeback

`default_nettype wire
